// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: one down-counter per architectural register,
// RAW/WAW stall generation for decode, and a saturating stall counter.
module hazard_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned LW   = 3,
    parameter int unsigned PW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs_addr,
    input  logic [AW-1:0]   issue_rt_addr,
    input  logic            issue_rs_used,
    input  logic            issue_rt_used,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_wr_addr,
    input  logic [LW-1:0]   issue_lat,
    input  logic            flush,
    output logic            stall,
    output logic            issue_accept,
    output logic [NREG-1:0] busy,
    output logic            idle,
    output logic [PW-1:0]   stall_count
);

    localparam logic [PW-1:0] SC_MAX = '1;

    // Register 0 has no storage; it reads as a permanently zero counter.
    logic [LW-1:0] cnt_q    [1:NREG-1];
    logic [LW-1:0] cnt_d    [1:NREG-1];
    logic [LW-1:0] cnt_view [NREG];

    logic [LW-1:0] rs_cnt;
    logic [LW-1:0] rt_cnt;
    logic [LW-1:0] wr_cnt;
    logic          raw_rs;
    logic          raw_rt;
    logic          waw;
    logic          load;

    always_comb begin
        cnt_view[0] = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            cnt_view[r] = cnt_q[r];
        end
    end

    // Hazard detection against the pre-edge counter values.
    always_comb begin
        rs_cnt       = cnt_view[issue_rs_addr];
        rt_cnt       = cnt_view[issue_rt_addr];
        wr_cnt       = cnt_view[issue_wr_addr];
        raw_rs       = issue_rs_used & (rs_cnt != '0);
        raw_rt       = issue_rt_used & (rt_cnt != '0);
        waw          = issue_we & (issue_wr_addr != '0) & (wr_cnt > issue_lat);
        stall        = issue_valid & ~flush & (raw_rs | raw_rt | waw);
        issue_accept = issue_valid & ~stall & ~flush;
        load         = issue_accept & issue_we & (issue_wr_addr != '0) & (issue_lat != '0);
    end

    // Counter next state: decrement, then issue load, then flush wins.
    always_comb begin
        for (int unsigned r = 1; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LW'(1) : '0;
            if (load && (issue_wr_addr == AW'(r))) begin
                cnt_d[r] = issue_lat;
            end
            if (flush) begin
                cnt_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != SC_MAX)) begin
            stall_count <= stall_count + PW'(1);
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            busy[r] = (cnt_view[r] != '0);
        end
        idle = ~|busy;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a ready-time model checked every cycle against
// two DUT instances (PW=16 and PW=4), plus directed literal expectations.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs_addr;
    logic [4:0]  issue_rt_addr;
    logic        issue_rs_used;
    logic        issue_rt_used;
    logic        issue_we;
    logic [4:0]  issue_wr_addr;
    logic [2:0]  issue_lat;
    logic        flush;

    logic        stall,  stall4;
    logic        issue_accept, issue_accept4;
    logic [31:0] busy,   busy4;
    logic        idle,   idle4;
    logic [15:0] stall_count;
    logic [3:0]  stall_count4;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Model: absolute cycle at which each register's result becomes forwardable.
    longint ready_at [32];
    longint cyc = 0;
    int     sc16 = 0;
    int     sc4  = 0;

    hazard_scoreboard #(.NREG(32), .AW(5), .LW(3), .PW(16)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs_addr(issue_rs_addr), .issue_rt_addr(issue_rt_addr),
        .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
        .issue_we(issue_we), .issue_wr_addr(issue_wr_addr), .issue_lat(issue_lat),
        .flush(flush), .stall(stall), .issue_accept(issue_accept),
        .busy(busy), .idle(idle), .stall_count(stall_count)
    );

    hazard_scoreboard #(.NREG(32), .AW(5), .LW(3), .PW(4)) dut4 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .issue_rs_addr(issue_rs_addr), .issue_rt_addr(issue_rt_addr),
        .issue_rs_used(issue_rs_used), .issue_rt_used(issue_rt_used),
        .issue_we(issue_we), .issue_wr_addr(issue_wr_addr), .issue_lat(issue_lat),
        .flush(flush), .stall(stall4), .issue_accept(issue_accept4),
        .busy(busy4), .idle(idle4), .stall_count(stall_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint rem(input logic [4:0] r);
        if (r == 5'd0) return 0;
        return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
    endfunction

    function automatic logic m_stall();
        if (!issue_valid || flush) return 1'b0;
        if (issue_rs_used && rem(issue_rs_addr) > 0) return 1'b1;
        if (issue_rt_used && rem(issue_rt_addr) > 0) return 1'b1;
        if (issue_we && issue_wr_addr != 5'd0 && rem(issue_wr_addr) > longint'(issue_lat)) return 1'b1;
        return 1'b0;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic        s;
        logic        a;
        logic [31:0] eb;
        if (chk_en) begin
            s  = m_stall();
            a  = issue_valid && !s && !flush;
            eb = '0;
            for (int r = 1; r < 32; r++) eb[r] = (rem(5'(r)) > 0);
            chk("stall", 64'(stall), 64'(s));
            chk("accept", 64'(issue_accept), 64'(a));
            chk("busy", 64'(busy), 64'(eb));
            chk("idle", 64'(idle), 64'(eb == 0));
            chk("stall_count", 64'(stall_count), 64'(sc16));
            chk("stall4", 64'(stall4), 64'(s));
            chk("accept4", 64'(issue_accept4), 64'(a));
            chk("busy4", 64'(busy4), 64'(eb));
            chk("idle4", 64'(idle4), 64'(eb == 0));
            chk("stall_count4", 64'(stall_count4), 64'(sc4));
        end
    end

    // Model state update on each rising edge.
    always @(posedge clk) begin
        logic s;
        logic a;
        s = m_stall();
        a = issue_valid && !s && !flush;
        if (!rst) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
            sc16 = 0;
            sc4  = 0;
        end else begin
            if (s) begin
                if (sc16 < 65535) sc16++;
                if (sc4 < 15) sc4++;
            end
            if (flush) begin
                for (int r = 0; r < 32; r++) ready_at[r] = 0;
            end else if (a && issue_we && issue_wr_addr != 5'd0 && issue_lat != 3'd0) begin
                ready_at[issue_wr_addr] = cyc + 1 + longint'(issue_lat);
            end
        end
        cyc++;
    end

    task automatic drv(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic we,
                       input logic [4:0] wr, input logic [2:0] lat,
                       input logic fl, input logic rn);
        issue_valid   = v;
        issue_rs_addr = rs;
        issue_rs_used = rsu;
        issue_rt_addr = rt;
        issue_rt_used = rtu;
        issue_we      = we;
        issue_wr_addr = wr;
        issue_lat     = lat;
        flush         = fl;
        rst           = rn;
        #1;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        nop();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_sc", 64'(stall_count), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        tick();

        // Load-use: one stall cycle.
        drv(1, 0, 0, 0, 0, 1, 8, 1, 0, 1);
        chk("A_lw_accept", 64'(issue_accept), 64'd1);
        tick();
        drv(1, 8, 1, 0, 0, 1, 10, 0, 0, 1);
        chk("A_use_stall", 64'(stall), 64'd1);
        chk("A_use_noacc", 64'(issue_accept), 64'd0);
        tick();
        drv(1, 8, 1, 0, 0, 1, 10, 0, 0, 1);
        chk("A_use_go", 64'(issue_accept), 64'd1);
        tick();
        nop();
        chk("A_sc", 64'(stall_count), 64'd1);
        tick();

        // Multi-cycle producer with latency 4.
        drv(1, 0, 0, 0, 0, 1, 9, 4, 0, 1);
        chk("B_mul_accept", 64'(issue_accept), 64'd1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drv(1, 9, 1, 0, 0, 1, 10, 0, 0, 1);
            if (k <= 4) begin
                chk("B_stall", 64'(stall), 64'd1);
                chk("B_busy9", 64'(busy[9]), 64'd1);
            end else begin
                chk("B_go", 64'(issue_accept), 64'd1);
                chk("B_busy9_clr", 64'(busy[9]), 64'd0);
            end
            tick();
        end
        nop();
        chk("B_sc", 64'(stall_count), 64'd5);
        tick();

        // WAW: zero-latency rewrite waits out the older long write.
        drv(1, 0, 0, 0, 0, 1, 9, 4, 0, 1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drv(1, 0, 0, 0, 0, 1, 9, 0, 0, 1);
            if (k <= 4) chk("C_waw_stall", 64'(stall), 64'd1);
            else        chk("C_waw_go", 64'(issue_accept), 64'd1);
            tick();
        end
        nop();
        tick();
        // WAW boundary: cnt > lat stalls, cnt == lat issues.
        drv(1, 0, 0, 0, 0, 1, 9, 4, 0, 1);
        tick();
        drv(1, 0, 0, 0, 0, 1, 9, 3, 0, 1);
        chk("C_gt_stall", 64'(stall), 64'd1);
        tick();
        drv(1, 0, 0, 0, 0, 1, 9, 3, 0, 1);
        chk("C_eq_go", 64'(issue_accept), 64'd1);
        tick();
        nop();
        chk("C_busy9", 64'(busy[9]), 64'd1);
        tick();
        n = 0;
        drv(1, 0, 0, 9, 1, 0, 0, 0, 0, 1);
        while (stall && n < 8) begin
            tick();
            drv(1, 0, 0, 9, 1, 0, 0, 0, 0, 1);
            n++;
        end
        chk("C_dep_stalls", 64'(n), 64'd2);
        tick();

        // Zero register is never tracked and never stalls.
        drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        chk("D_lw0_accept", 64'(issue_accept), 64'd1);
        tick();
        drv(1, 0, 1, 0, 1, 1, 11, 0, 0, 1);
        chk("D_nostall", 64'(stall), 64'd0);
        chk("D_busy", 64'(busy), 64'd0);
        tick();

        // Flush beats a same-cycle issue and forces stall low.
        drv(1, 0, 0, 0, 0, 1, 5, 7, 0, 1);
        tick();
        drv(0, 5, 1, 0, 0, 1, 7, 3, 0, 1);
        chk("E_novalid_stall", 64'(stall), 64'd0);
        tick();
        drv(1, 5, 1, 0, 0, 1, 6, 2, 1, 1);
        chk("E_fl_stall", 64'(stall), 64'd0);
        chk("E_fl_accept", 64'(issue_accept), 64'd0);
        tick();
        nop();
        chk("E_fl_busy", 64'(busy), 64'd0);
        chk("E_fl_idle", 64'(idle), 64'd1);
        tick();
        drv(1, 6, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("E_fl_r6", 64'(stall), 64'd0);
        tick();

        // Reset mid-countdown ignores the same-cycle issue.
        drv(1, 0, 0, 0, 0, 1, 5, 7, 0, 1);
        tick();
        nop();
        tick();
        drv(1, 0, 0, 0, 0, 1, 6, 2, 0, 0);
        chk("E_rst_accept", 64'(issue_accept), 64'd1);
        tick();
        nop();
        chk("E_rst_busy", 64'(busy), 64'd0);
        chk("E_rst_idle", 64'(idle), 64'd1);
        chk("E_rst_sc", 64'(stall_count), 64'd0);
        chk("E_rst_sc4", 64'(stall_count4), 64'd0);
        tick();
        drv(1, 6, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("E_rst_r6", 64'(stall), 64'd0);
        tick();

        // Saturation: 21 stall cycles overflow the 4-bit counter.
        for (int round = 0; round < 3; round++) begin
            drv(1, 0, 0, 0, 0, 1, 3, 7, 0, 1);
            tick();
            for (int k = 1; k <= 7; k++) begin
                drv(1, 3, 1, 0, 0, 1, 12, 0, 0, 1);
                tick();
            end
        end
        drv(1, 3, 1, 0, 0, 1, 12, 0, 0, 1);
        chk("F_go", 64'(issue_accept), 64'd1);
        chk("F_sc16", 64'(stall_count), 64'd21);
        chk("F_sc4", 64'(stall_count4), 64'd15);
        tick();
        for (int k = 0; k < 3; k++) begin
            nop();
            tick();
        end
        nop();
        chk("F_sc4_held", 64'(stall_count4), 64'd15);
        tick();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
